spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_tick_gen.sv | 28 ++
 rtl/spi_master.sv | 134 +++++++++++++
 tb/tb_spi_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: frame layout, field positions and FSM states.
// The frame helper is the single place where the 40-bit frame layout is assembled.
package spi_pkg;

  localparam int FRAME_BITS = 40;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 32;

  // Header field positions inside the frame (MSB is shifted out first)
  localparam int RW_POS   = 39;
  localparam int ADDR_MSB = 38;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } spi_state_e;

  // Reads carry an all-zero data field
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 rw,
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] wdata
  );
    build_frame = {rw, addr, (rw ? wdata : {DATA_BITS{1'b0}})};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: reloads CLK_DIV-1 on restart, counts down to zero and holds there.
// tick is high while the count is zero, i.e. on the last cycle of the current state.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master issuing 40-bit frames {rw, addr[6:0], data[31:0]}, MSB first.
// All outputs are registered; the state is exported on dbg_state for checkers.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rw,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 spi_clk,
  output logic                 spi_cs,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output spi_state_e           dbg_state
);

  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS);

  // Request handshake: start acts as valid and !busy as ready. A start seen
  // while busy is high is dropped, never queued; done marks frame completion.

  spi_state_e            state;
  logic                  tick;
  logic                  restart;
  logic                  rw_q;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-2:0] tx_sr;
  logic [DATA_BITS-1:0]  rx_sr;
  logic [FRAME_BITS-1:0] frame;

  assign frame     = build_frame(rw, addr, wdata);
  assign dbg_state = state;

  // Every non-idle state ends on tick, so the timer reloads on each state entry.
  assign restart = (state == IDLE) ? start : tick;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      spi_clk  <= 1'b0;
      spi_cs   <= 1'b1;
      spi_mosi <= 1'b0;
      rw_q     <= 1'b0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            busy     <= 1'b1;
            spi_cs   <= 1'b0;
            rw_q     <= rw;
            spi_mosi <= frame[RW_POS];
            tx_sr    <= frame[FRAME_BITS-2:0];
            bit_cnt  <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state   <= SCK_HI;
            spi_clk <= 1'b1;
            bit_cnt <= bit_cnt + 6'd1;
            rx_sr   <= {rx_sr[DATA_BITS-2:0], spi_miso};
          end
        end
        SCK_HI: begin
          // Falling edge: present the next bit; zeros trail in after the last one
          if (tick) begin
            state    <= SCK_LO;
            spi_clk  <= 1'b0;
            spi_mosi <= tx_sr[FRAME_BITS-2];
            tx_sr    <= {tx_sr[FRAME_BITS-3:0], 1'b0};
          end
        end
        SCK_LO: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              // The 32-bit receive register lets the header bits fall off the top
              state   <= SCK_HI;
              spi_clk <= 1'b1;
              bit_cnt <= bit_cnt + 6'd1;
              rx_sr   <= {rx_sr[DATA_BITS-2:0], spi_miso};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state    <= GAP;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            if (!rw_q) begin
              rdata <= rx_sr;
            end
          end
        end
        GAP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master at CLK_DIV = 2, 1 and 255 with a behavioural mode-0 slave per instance.
// Expected frames, latencies and rdata come from a frame-level model of the transaction rules.
module tb_spi_master;

  localparam int NDUT = 3;
  localparam int DIVS [NDUT] = '{2, 1, 255};

  logic        clk = 1'b0;
  logic        reset    [NDUT];
  logic        start    [NDUT];
  logic        rw       [NDUT];
  logic [6:0]  addr     [NDUT];
  logic [31:0] wdata    [NDUT];
  logic        busy     [NDUT];
  logic        done     [NDUT];
  logic [31:0] rdata    [NDUT];
  logic        spi_clk  [NDUT];
  logic        spi_cs   [NDUT];
  logic        spi_mosi [NDUT];
  logic        spi_miso [NDUT];
  spi_pkg::spi_state_e dbg_state [NDUT];

  // slave model and monitor state
  logic [39:0] sl_tx      [NDUT];
  logic [39:0] sl_cap     [NDUT];
  int          sl_rise    [NDUT];
  int          sl_idx     [NDUT];
  int          cs_falls   [NDUT];
  int          fall_cyc   [NDUT];
  int          done_cnt   [NDUT];
  int          done_cyc   [NDUT];
  int          mosi_viol  [NDUT];
  logic [31:0] done_rdata [NDUT];
  logic        prev_cs    [NDUT];
  logic        prev_sclk  [NDUT];

  // reference model
  logic [39:0] exp_frame [NDUT];
  logic        exp_rw    [NDUT];
  logic [31:0] exp_rdata [NDUT];
  int          t0        [NDUT];
  int          prev_done [NDUT];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spi_master #(
      .CLK_DIV (DIVS[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .start     (start[g]),
      .rw        (rw[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .spi_clk   (spi_clk[g]),
      .spi_cs    (spi_cs[g]),
      .spi_mosi  (spi_mosi[g]),
      .spi_miso  (spi_miso[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // Mode-0 slave: shifts out sl_tx from cs fall, changes MISO after SCLK falls,
  // captures MOSI on SCLK rise. Also timestamps cs falls and done pulses.
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (prev_cs[g] === 1'b1 && spi_cs[g] === 1'b0) begin
        sl_cap[g]   = '0;
        sl_rise[g]  = 0;
        sl_idx[g]   = 0;
        spi_miso[g] = sl_tx[g][39];
        cs_falls[g]++;
        fall_cyc[g] = cyc;
      end else if (spi_cs[g] === 1'b0) begin
        if (prev_sclk[g] === 1'b0 && spi_clk[g] === 1'b1) begin
          sl_cap[g] = {sl_cap[g][38:0], spi_mosi[g]};
          sl_rise[g]++;
        end
        if (prev_sclk[g] === 1'b1 && spi_clk[g] === 1'b0) begin
          sl_idx[g]++;
          spi_miso[g] = (sl_idx[g] < 40) ? sl_tx[g][39 - sl_idx[g]] : 1'b0;
        end
      end
      if (spi_cs[g] === 1'b1 && spi_mosi[g] !== 1'b0) mosi_viol[g]++;
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        done_cyc[g]   = cyc;
        done_rdata[g] = rdata[g];
      end
      prev_cs[g]   = spi_cs[g];
      prev_sclk[g] = spi_clk[g];
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int k, input logic r, input logic [6:0] a,
                        input logic [31:0] w, input logic [39:0] stx);
    sl_tx[k]     = stx;
    exp_frame[k] = {r, a, (r ? w : 32'h0)};
    exp_rw[k]    = r;
    prev_done[k] = done_cnt[k];
    rw[k]    = r;
    addr[k]  = a;
    wdata[k] = w;
    start[k] = 1'b1;
    t0[k]    = cyc;
    step();
    start[k] = 1'b0;
    rw[k]    = 1'($urandom_range(0, 1));
    addr[k]  = 7'($urandom);
    wdata[k] = $urandom;
    check("start_cs_low", 64'(spi_cs[k]), 64'd0);
    check("start_busy", 64'(busy[k]), 64'd1);
    check("start_mosi_msb", 64'(spi_mosi[k]), 64'(r));
  endtask

  task automatic finish_frame(input int k);
    int d = DIVS[k];
    bit got = 1'b0;
    for (int i = 0; i < 82 * d + 40 && !got; i++) begin
      step();
      if (done_cnt[k] != prev_done[k]) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(done_cyc[k] - t0[k]), 64'(82 * d + 1));
    check("frame", 64'(sl_cap[k]), 64'(exp_frame[k]));
    check("sclk_rises", 64'(sl_rise[k]), 64'd40);
    if (!exp_rw[k]) exp_rdata[k] = sl_tx[k][31:0];
    check("rdata_done", 64'(done_rdata[k]), 64'(exp_rdata[k]));
    check("done_cs", 64'(spi_cs[k]), 64'd1);
    check("done_busy", 64'(busy[k]), 64'd1);
    check("done_mosi", 64'(spi_mosi[k]), 64'd0);
    for (int i = 1; i <= d; i++) begin
      step();
      if (i == 1) check("done_pulse_width", 64'(done[k]), 64'd0);
      if (i == d - 1) check("gap_busy", 64'(busy[k]), 64'd1);
    end
    check("idle_busy", 64'(busy[k]), 64'd0);
    check("idle_cs", 64'(spi_cs[k]), 64'd1);
    check("done_count", 64'(done_cnt[k] - prev_done[k]), 64'd1);
    check("rdata_hold", 64'(rdata[k]), 64'(exp_rdata[k]));
  endtask

  initial begin
    int       falls0;
    int       dones0;
    bit       got;
    logic     r;
    logic [6:0]  a;
    logic [31:0] w;

    for (int k = 0; k < NDUT; k++) begin
      reset[k] = 1'b1;  start[k] = 1'b0;  rw[k] = 1'b0;
      addr[k] = '0;     wdata[k] = '0;    spi_miso[k] = 1'b0;
      sl_tx[k] = '0;    sl_cap[k] = '0;   sl_rise[k] = 0;  sl_idx[k] = 0;
      cs_falls[k] = 0;  fall_cyc[k] = 0;  done_cnt[k] = 0; done_cyc[k] = 0;
      mosi_viol[k] = 0; done_rdata[k] = '0;
      prev_cs[k] = 1'b1; prev_sclk[k] = 1'b0;
      exp_frame[k] = '0; exp_rw[k] = 1'b0; exp_rdata[k] = '0;
      t0[k] = 0;        prev_done[k] = 0;
    end

    repeat (3) step();
    for (int k = 0; k < NDUT; k++) begin
      check("rst_cs", 64'(spi_cs[k]), 64'd1);
      check("rst_sclk", 64'(spi_clk[k]), 64'd0);
      check("rst_mosi", 64'(spi_mosi[k]), 64'd0);
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_done", 64'(done[k]), 64'd0);
      check("rst_rdata", 64'(rdata[k]), 64'd0);
      check("rst_state", 64'(dbg_state[k]), 64'(spi_pkg::IDLE));
      reset[k] = 1'b0;
    end
    step();

    // write: slave must see 40'h85DEADBEEF, rdata stays 0
    launch(0, 1'b1, 7'h05, 32'hDEADBEEF, {8'($urandom), 32'($urandom)});
    finish_frame(0);
    check("write_frame_lit", 64'(sl_cap[0]), 64'h85DEADBEEF);
    check("write_rdata_zero", 64'(rdata[0]), 64'd0);

    // read of 32'h3F800000 with a junk header byte from the slave
    launch(0, 1'b0, 7'h10, $urandom, {8'($urandom), 32'h3F800000});
    finish_frame(0);
    check("read_header", 64'(sl_cap[0][39:32]), 64'h10);
    check("read_rdata_lit", 64'(done_rdata[0]), 64'h3F800000);

    // a start with a different address mid-frame is ignored
    launch(0, 1'b0, 7'h2A, 32'h0, {8'h5C, 32'h0BADF00D});
    while (cyc < t0[0] + 20) step();
    rw[0] = 1'b1; addr[0] = 7'h55; wdata[0] = 32'hFFFF0000; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    falls0 = cs_falls[0];
    finish_frame(0);
    dones0 = done_cnt[0];
    repeat (400) step();
    check("reject_no_frame", 64'(cs_falls[0] - falls0), 64'd0);
    check("reject_no_done", 64'(done_cnt[0] - dones0), 64'd0);

    // start held high across two frames
    a = 7'($urandom); w = $urandom;
    sl_tx[0] = {8'($urandom), 32'($urandom)};
    exp_frame[0] = {1'b1, a, w};
    exp_rw[0] = 1'b1;
    prev_done[0] = done_cnt[0];
    falls0 = cs_falls[0];
    rw[0] = 1'b1; addr[0] = a; wdata[0] = w; start[0] = 1'b1;
    t0[0] = cyc;
    step();
    check("b2b_cs_low", 64'(spi_cs[0]), 64'd0);
    finish_frame(0);
    step();
    check("b2b_second_fall", 64'(cs_falls[0] - falls0), 64'd2);
    check("b2b_fall_gap", 64'(fall_cyc[0] - done_cyc[0]), 64'(DIVS[0] + 1));
    start[0] = 1'b0;
    t0[0] = fall_cyc[0] - 1;
    prev_done[0] = done_cnt[0];
    finish_frame(0);
    dones0 = done_cnt[0];
    repeat (400) step();
    check("b2b_no_extra", 64'(cs_falls[0] - falls0), 64'd2);
    check("b2b_no_extra_done", 64'(done_cnt[0] - dones0), 64'd0);

    // reset at the 17th SCLK rising edge aborts the frame
    launch(0, 1'b0, 7'($urandom), $urandom, {8'($urandom), 32'hCAFE0001});
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (sl_rise[0] == 17) got = 1'b1;
      else step();
    end
    check("rise17_seen", 64'(got), 64'd1);
    dones0 = done_cnt[0];
    reset[0] = 1'b1;
    step();
    reset[0] = 1'b0;
    exp_rdata[0] = '0;
    check("abort_cs", 64'(spi_cs[0]), 64'd1);
    check("abort_sclk", 64'(spi_clk[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_rdata", 64'(rdata[0]), 64'd0);
    repeat (300) step();
    check("abort_no_done", 64'(done_cnt[0] - dones0), 64'd0);
    launch(0, 1'b0, 7'($urandom), $urandom, {8'($urandom), 32'h12345678});
    finish_frame(0);
    check("post_abort_rdata", 64'(rdata[0]), 64'h12345678);

    // reset wins over start in the same cycle
    reset[0] = 1'b1; start[0] = 1'b1; rw[0] = 1'b1;
    step();
    reset[0] = 1'b0; start[0] = 1'b0;
    check("rst_prio_cs", 64'(spi_cs[0]), 64'd1);
    check("rst_prio_busy", 64'(busy[0]), 64'd0);
    exp_rdata[0] = '0;
    step();
    check("rst_prio_idle", 64'(busy[0]), 64'd0);

    // randomized frames at CLK_DIV = 2
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom_range(0, 1));
      launch(0, r, 7'($urandom), $urandom, {8'($urandom), 32'($urandom)});
      finish_frame(0);
    end

    // extreme dividers: one write and one read each
    for (int k = 1; k < NDUT; k++) begin
      launch(k, 1'b1, 7'($urandom), $urandom, {8'($urandom), 32'($urandom)});
      finish_frame(k);
      launch(k, 1'b0, 7'($urandom), $urandom, {8'($urandom), 32'($urandom)});
      finish_frame(k);
    end

    for (int k = 0; k < NDUT; k++) begin
      check("mosi_zero_when_cs_high", 64'(mosi_viol[k]), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
